// File: rtl/gate_tt_checker.sv
// gate_tt_checker: sweeps all input vectors of a gate under test and checks its truth table.
// Optional GTC_ABORT_ON_FAIL_EN ends the sweep at the first mismatching vector.
module gate_tt_checker #(
  parameter int N_IN = 2,
  parameter int SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0] EXP_TT = 4'b0111
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [N_IN-1:0]       dut_in,
  input  logic                  dut_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [(1<<N_IN)-1:0]  captured_tt,
  output logic [N_IN:0]         mismatch_cnt,
  output logic [N_IN-1:0]       first_fail_idx
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CMAX = CW'(SETTLE - 1);
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [N_IN-1:0] LAST = N_IN'((1 << N_IN) - 1);
  localparam logic [N_IN-1:0] ONE_I = N_IN'(1);
  localparam logic [N_IN:0] ONE_M = (N_IN + 1)'(1);
  localparam logic [N_IN:0] ZERO_M = '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t state, state_nx;
  logic [N_IN-1:0] idx;
  logic [CW-1:0] cnt;
  logic miss;
  logic last;

  // X/Z on the gate output must count as a failure, hence the 4-state compare
  assign miss = (dut_out !== EXP_TT[idx]);
  assign last = (idx == LAST);
  assign done = (state == S_DONE);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (start) state_nx = S_SETTLE;
      S_SETTLE: if (cnt == CMAX) state_nx = S_SAMPLE;
`ifdef GTC_ABORT_ON_FAIL_EN
      S_SAMPLE: state_nx = (miss || last) ? S_DONE : S_SETTLE;
`else
      S_SAMPLE: state_nx = last ? S_DONE : S_SETTLE;
`endif
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // sweep datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx            <= '0;
      cnt            <= '0;
      dut_in         <= '0;
      busy           <= 1'b0;
      pass           <= 1'b0;
      captured_tt    <= '0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            idx            <= '0;
            cnt            <= '0;
            dut_in         <= '0;
            busy           <= 1'b1;
            pass           <= 1'b0;
            captured_tt    <= '0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
          end
        end
        S_SETTLE: begin
          if (cnt == CMAX) cnt <= '0;
          else             cnt <= cnt + ONE_C;
        end
        S_SAMPLE: begin
          captured_tt[idx] <= dut_out;
          if (miss) begin
            mismatch_cnt <= mismatch_cnt + ONE_M;
            if (mismatch_cnt == ZERO_M) first_fail_idx <= idx;
          end
          if (state_nx == S_SETTLE) begin
            idx    <= idx + ONE_I;
            dut_in <= idx + ONE_I;
          end else begin
            pass <= !miss && (mismatch_cnt == ZERO_M);
          end
        end
        S_DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tt_checker.sv
// tb_gate_tt_checker: directed sweeps of gate_tt_checker against modelled gates.
// Expected results are hand-derived for default N_IN=2, SETTLE=2, EXP_TT=NAND.
module tb_gate_tt_checker;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] dut_in;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] captured_tt;
  logic [2:0] mismatch_cnt;
  logic [1:0] first_fail_idx;

  int mode;
  int n_checks;
  int n_fail;

  gate_tt_checker dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dut_in(dut_in),
    .dut_out(dut_out),
    .busy(busy),
    .done(done),
    .pass(pass),
    .captured_tt(captured_tt),
    .mismatch_cnt(mismatch_cnt),
    .first_fail_idx(first_fail_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // gate models: 0 NAND, 1 stuck-at-1, 2 AND, 3 stuck-at-0
  always_comb begin
    dut_out = 1'b0;
    case (mode)
      0: dut_out = ~(dut_in[1] & dut_in[0]);
      1: dut_out = 1'b1;
      2: dut_out = dut_in[1] & dut_in[0];
      default: dut_out = 1'b0;
    endcase
  end

  task automatic run_sweep(input int m, output int first_done,
                           output int n_done, output int seq_bad);
    int e;
    mode = m;
    first_done = -1;
    n_done = 0;
    seq_bad = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      e = (k / 3 > 3) ? 3 : k / 3;
      if (m == 0 && k <= 12 && dut_in !== e[1:0]) seq_bad++;
      if (m == 0 && k <= 12 && busy !== 1'b1) seq_bad++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    mode = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy, done, pass} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got=%b want=000", {busy, done, pass});
    end
    n_checks++;
    if (dut_in !== 2'd0 || captured_tt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_vec got dut_in=%b tt=%b want 0", dut_in, captured_tt);
    end
    n_checks++;
    if (mismatch_cnt !== 3'd0 || first_fail_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_cnt got cnt=%0d ffi=%0d want 0", mismatch_cnt, first_fail_idx);
    end
  endtask

  task automatic test_nand();
    int fd, nd, sb;
    run_sweep(0, fd, nd, sb);
    n_checks++;
    if (fd != 12 || nd != 1) begin
      n_fail++;
      $display("FAIL nand_done got edge=%0d count=%0d want 12/1", fd, nd);
    end
    n_checks++;
    if (sb != 0) begin
      n_fail++;
      $display("FAIL nand_seq got errors=%0d want 0", sb);
    end
    n_checks++;
    if (captured_tt !== 4'b0111 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL nand_tt got tt=%b pass=%b want 0111/1", captured_tt, pass);
    end
    n_checks++;
    if (mismatch_cnt !== 3'd0 || first_fail_idx !== 2'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nand_res got cnt=%0d ffi=%0d busy=%b want 0/0/0",
               mismatch_cnt, first_fail_idx, busy);
    end
  endtask

  task automatic test_stuck1();
    int fd, nd, sb;
    run_sweep(1, fd, nd, sb);
    n_checks++;
    if (fd != 12 || nd != 1) begin
      n_fail++;
      $display("FAIL s1_done got edge=%0d count=%0d want 12/1", fd, nd);
    end
    n_checks++;
    if (captured_tt !== 4'b1111 || mismatch_cnt !== 3'd1 ||
        first_fail_idx !== 2'd3 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL s1_res got tt=%b cnt=%0d ffi=%0d pass=%b want 1111/1/3/0",
               captured_tt, mismatch_cnt, first_fail_idx, pass);
    end
  endtask

  task automatic test_and();
    int fd, nd, sb;
    int exp_fd;
    logic [3:0] exp_tt;
    logic [2:0] exp_cnt;
`ifdef GTC_ABORT_ON_FAIL_EN
    exp_fd = 3; exp_tt = 4'b0000; exp_cnt = 3'd1;
`else
    exp_fd = 12; exp_tt = 4'b1000; exp_cnt = 3'd4;
`endif
    run_sweep(2, fd, nd, sb);
    n_checks++;
    if (fd != exp_fd || nd != 1) begin
      n_fail++;
      $display("FAIL and_done got edge=%0d count=%0d want %0d/1", fd, nd, exp_fd);
    end
    n_checks++;
    if (captured_tt !== exp_tt || mismatch_cnt !== exp_cnt ||
        first_fail_idx !== 2'd0 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL and_res got tt=%b cnt=%0d ffi=%0d pass=%b want %b/%0d/0/0",
               captured_tt, mismatch_cnt, first_fail_idx, pass, exp_tt, exp_cnt);
    end
  endtask

  task automatic test_stuck0();
    int fd, nd, sb;
    int exp_fd;
    logic [2:0] exp_cnt;
    logic [1:0] exp_in;
`ifdef GTC_ABORT_ON_FAIL_EN
    exp_fd = 3; exp_cnt = 3'd1; exp_in = 2'd0;
`else
    exp_fd = 12; exp_cnt = 3'd3; exp_in = 2'd3;
`endif
    run_sweep(3, fd, nd, sb);
    n_checks++;
    if (fd != exp_fd || nd != 1) begin
      n_fail++;
      $display("FAIL s0_done got edge=%0d count=%0d want %0d/1", fd, nd, exp_fd);
    end
    n_checks++;
    if (captured_tt !== 4'b0000 || mismatch_cnt !== exp_cnt ||
        first_fail_idx !== 2'd0 || dut_in !== exp_in) begin
      n_fail++;
      $display("FAIL s0_res got tt=%b cnt=%0d ffi=%0d in=%0d want 0000/%0d/0/%0d",
               captured_tt, mismatch_cnt, first_fail_idx, dut_in, exp_cnt, exp_in);
    end
  endtask

  task automatic test_back_to_back();
    int nd, fd;
    int busy_bad;
    mode = 0;
    nd = 0;
    fd = -1;
    busy_bad = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      start = (k == 4 || k == 12);
      @(negedge clk);
      if (done) begin
        nd++;
        if (fd < 0) fd = k;
      end
      if (k <= 12 && busy !== 1'b1) busy_bad++;
      if (k == 13 && (busy !== 1'b0 || done !== 1'b0)) busy_bad++;
    end
    start = 1'b0;
    n_checks++;
    if (fd != 12 || nd != 1) begin
      n_fail++;
      $display("FAIL b2b_done got edge=%0d count=%0d want 12/1", fd, nd);
    end
    n_checks++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL b2b_busy got errors=%0d want 0", busy_bad);
    end
    n_checks++;
    if (captured_tt !== 4'b0111 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_hold got tt=%b pass=%b want 0111/1", captured_tt, pass);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || captured_tt !== 4'b0000 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_restart got busy=%b tt=%b pass=%b want 1/0000/0",
               busy, captured_tt, pass);
    end
    repeat (16) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int fd, nd, sb;
    int stray;
    mode = 2;
    stray = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || dut_in !== 2'd0 || done !== 1'b0 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flags got busy=%b in=%0d done=%b pass=%b want 0",
               busy, dut_in, done, pass);
    end
    n_checks++;
    if (captured_tt !== 4'd0 || mismatch_cnt !== 3'd0 || first_fail_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_res got tt=%b cnt=%0d ffi=%0d want 0",
               captured_tt, mismatch_cnt, first_fail_idx);
    end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL rst_quiet got activity=%0d want 0", stray);
    end
    run_sweep(0, fd, nd, sb);
    n_checks++;
    if (fd != 12 || nd != 1 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_resweep got edge=%0d count=%0d pass=%b want 12/1/1",
               fd, nd, pass);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    start = 1'b0;
    mode = 0;
    test_reset();
    test_nand();
    test_stuck1();
    test_and();
    test_stuck0();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
